// File: rtl/ysyx_23060072_lsu_stage.sv
// Load/store stage: passes ALU results straight to writeback, or runs one
// bus transaction (request, then response) per memory op and commits it.
module ysyx_23060072_lsu_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        ex_wb_flag_i,
    input  logic [4:0]  ex_wb_addr_i,
    input  logic [31:0] ex_result_i,
    input  logic [31:0] ex_store_data_i,
    input  logic        ex_mem_ren_i,
    input  logic        ex_mem_wen_i,
    input  logic [1:0]  ex_mem_size_i,
    input  logic        ex_mem_unsigned_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    output logic        mem_req_wen_o,
    output logic [31:0] mem_req_wdata_o,
    output logic [3:0]  mem_req_wstrb_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_rdata_i,
    output logic        wb_flag_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        lsu_misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, state_nxt;

    logic        accept, is_mem, misalign, start_mem;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;

    logic [1:0]  lat_lo;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic [4:0]  lat_rd;
    logic        lat_flag;
    logic        lat_store;
    logic [31:0] lane;
    logic [31:0] load_data;

    assign ex_ready_o      = (state == IDLE);
    assign mem_req_valid_o = (state == REQ);

    assign accept    = ex_valid_i & ex_ready_o;
    assign is_mem    = ex_mem_ren_i | ex_mem_wen_i;
    assign misalign  = (ex_mem_size_i == 2'b11)
                     | ((ex_mem_size_i == 2'b01) & ex_result_i[0])
                     | ((ex_mem_size_i == 2'b10) & (ex_result_i[1:0] != 2'b00));
    assign start_mem = accept & is_mem & ~misalign;

    always_comb begin
        wstrb_c = 4'b1111;
        wdata_c = ex_store_data_i;
        case (ex_mem_size_i)
            2'b00: begin
                wstrb_c = 4'b0001 << ex_result_i[1:0];
                wdata_c = {4{ex_store_data_i[7:0]}};
            end
            2'b01: begin
                wstrb_c = ex_result_i[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{ex_store_data_i[15:0]}};
            end
            default: ;
        endcase
        if (!ex_mem_wen_i) wstrb_c = '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_mem)       state_nxt = REQ;
            REQ:     if (mem_req_ready_i) state_nxt = WAIT;
            WAIT:    if (mem_rsp_valid_i) state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Response word is already word-aligned; shift the addressed lane down to bit 0.
    assign lane = mem_rsp_rdata_i >> {lat_lo, 3'b000};

    always_comb begin
        load_data = mem_rsp_rdata_i;
        case (lat_size)
            2'b00:   load_data = {{24{lane[7]  & ~lat_uns}}, lane[7:0]};
            2'b01:   load_data = {{16{lane[15] & ~lat_uns}}, lane[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_addr_o  <= '0;
            mem_req_wen_o   <= 1'b0;
            mem_req_wdata_o <= '0;
            mem_req_wstrb_o <= '0;
            lat_lo          <= '0;
            lat_size        <= '0;
            lat_uns         <= 1'b0;
            lat_rd          <= '0;
            lat_flag        <= 1'b0;
            lat_store       <= 1'b0;
            wb_flag_o       <= 1'b0;
            wb_addr_o       <= '0;
            wb_data_o       <= '0;
            lsu_misalign_o  <= 1'b0;
        end else begin
            wb_flag_o      <= 1'b0;
            lsu_misalign_o <= 1'b0;
            if (accept && !is_mem) begin
                wb_flag_o <= ex_wb_flag_i & (ex_wb_addr_i != 5'd0);
                wb_addr_o <= ex_wb_addr_i;
                wb_data_o <= ex_result_i;
            end else if (accept && misalign) begin
                lsu_misalign_o <= 1'b1;
            end else if (start_mem) begin
                mem_req_addr_o  <= {ex_result_i[31:2], 2'b00};
                mem_req_wen_o   <= ex_mem_wen_i;
                mem_req_wdata_o <= wdata_c;
                mem_req_wstrb_o <= wstrb_c;
                lat_lo          <= ex_result_i[1:0];
                lat_size        <= ex_mem_size_i;
                lat_uns         <= ex_mem_unsigned_i;
                lat_rd          <= ex_wb_addr_i;
                lat_flag        <= ex_wb_flag_i;
                lat_store       <= ex_mem_wen_i;
            end
            if (state == WAIT && mem_rsp_valid_i) begin
                wb_flag_o <= lat_flag & ~lat_store & (lat_rd != 5'd0);
                wb_addr_o <= lat_rd;
                if (!lat_store) wb_data_o <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060072_lsu_stage.sv
// Randomised self-checking bench for the load/store stage against an
// arithmetic reference of the access rules.
module tb_ysyx_23060072_lsu_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid_i = 1'b0;
    logic        ex_ready_o;
    logic        ex_wb_flag_i = 1'b0;
    logic [4:0]  ex_wb_addr_i = '0;
    logic [31:0] ex_result_i = '0;
    logic [31:0] ex_store_data_i = '0;
    logic        ex_mem_ren_i = 1'b0;
    logic        ex_mem_wen_i = 1'b0;
    logic [1:0]  ex_mem_size_i = '0;
    logic        ex_mem_unsigned_i = 1'b0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_req_addr_o;
    logic        mem_req_wen_o;
    logic [31:0] mem_req_wdata_o;
    logic [3:0]  mem_req_wstrb_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [31:0] mem_rsp_rdata_i = '0;
    logic        wb_flag_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic        lsu_misalign_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_23060072_lsu_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_wb_flag_i(ex_wb_flag_i), .ex_wb_addr_i(ex_wb_addr_i),
        .ex_result_i(ex_result_i), .ex_store_data_i(ex_store_data_i),
        .ex_mem_ren_i(ex_mem_ren_i), .ex_mem_wen_i(ex_mem_wen_i),
        .ex_mem_size_i(ex_mem_size_i), .ex_mem_unsigned_i(ex_mem_unsigned_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_wen_o(mem_req_wen_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wstrb_o(mem_req_wstrb_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i),
        .wb_flag_o(wb_flag_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
        .lsu_misalign_o(lsu_misalign_o)
    );

    // Reference rules, written as plain arithmetic.
    function automatic logic [31:0] ref_load(logic [31:0] rdata, logic [31:0] addr,
                                             logic [1:0] size, bit uns);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rdata >> (8 * (addr % 4));
        if (size == 2'd0) begin
            v = sh % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = sh % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_strb(bit st, logic [31:0] addr, logic [1:0] size);
        if (!st) return 4'h0;
        if (size == 2'd0) return 4'(1 << (addr % 4));
        if (size == 2'd1) return ((addr % 4) >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(logic [31:0] data, logic [1:0] size);
        if (size == 2'd0) return (data % 256) * 32'h0101_0101;
        if (size == 2'd1) return (data % 65536) * 32'h0001_0001;
        return data;
    endfunction

    function automatic bit ref_mis(logic [31:0] addr, logic [1:0] size);
        return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    endfunction

    task automatic garbage_upstream();
        ex_valid_i        = 1'b1;
        ex_mem_ren_i      = $urandom % 2;
        ex_mem_wen_i      = 1'b0;
        ex_wb_flag_i      = 1'b1;
        ex_wb_addr_i      = 5'($urandom_range(1, 31));
        ex_result_i       = $urandom;
        ex_store_data_i   = $urandom;
        ex_mem_size_i     = 2'($urandom % 4);
        ex_mem_unsigned_i = $urandom % 2;
    endtask

    task automatic test_reset();
        #2;
        if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid_o); end
        checks++;
        if (wb_flag_o !== 1'b0) begin errors++; $display("FAIL reset_wb_flag: got %b want 0", wb_flag_o); end
        checks++;
        if (lsu_misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", lsu_misalign_o); end
        checks++;
        if (wb_addr_o !== 5'd0 || wb_data_o !== 32'd0) begin
            errors++; $display("FAIL reset_wb_regs: got addr %0d data %h want 0/0", wb_addr_o, wb_data_o);
        end
        checks++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ex_ready_o); end
        checks++;
    endtask

    // Non-memory ops presented every cycle; the first one is the rd=5 / 0x1234 case.
    task automatic test_alu_back_to_back(int unsigned n);
        bit          have = 0;
        bit          pf = 0;
        logic [4:0]  pa = '0;
        logic [31:0] pd = '0;
        for (int unsigned i = 0; i <= n; i++) begin
            @(negedge clk);
            if (have) begin
                if (wb_flag_o !== pf) begin errors++; $display("FAIL alu_wb_flag[%0d]: got %b want %b", i, wb_flag_o, pf); end
                checks++;
                if (pf && (wb_addr_o !== pa || wb_data_o !== pd)) begin
                    errors++; $display("FAIL alu_wb[%0d]: got %0d/%h want %0d/%h", i, wb_addr_o, wb_data_o, pa, pd);
                end
                checks++;
                if (ex_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0 || lsu_misalign_o !== 1'b0) begin
                    errors++; $display("FAIL alu_ctrl[%0d]: got ready %b req %b mis %b want 1/0/0", i, ex_ready_o, mem_req_valid_o, lsu_misalign_o);
                end
                checks++;
            end
            if (i == n) break;
            ex_valid_i        = 1'b1;
            ex_mem_ren_i      = 1'b0;
            ex_mem_wen_i      = 1'b0;
            ex_mem_size_i     = 2'($urandom % 4);
            ex_mem_unsigned_i = $urandom % 2;
            ex_store_data_i   = $urandom;
            if (i == 0) begin
                ex_wb_flag_i = 1'b1; ex_wb_addr_i = 5'd5; ex_result_i = 32'h1234;
            end else begin
                ex_wb_flag_i = $urandom % 2;
                ex_wb_addr_i = (i % 5 == 0) ? 5'd0 : 5'($urandom % 32);
                ex_result_i  = $urandom;
            end
            pf = ex_wb_flag_i && ex_wb_addr_i != 0;
            pa = ex_wb_addr_i;
            pd = ex_result_i;
            have = 1;
        end
        ex_valid_i = 1'b0;
        @(negedge clk);
        if (wb_flag_o !== 1'b0) begin errors++; $display("FAIL alu_flag_drop: got %b want 0", wb_flag_o); end
        checks++;
    endtask

    // One memory op: acceptance, request held rdly extra cycles, response sdly cycles into WAIT.
    task automatic do_mem(string name, bit st, logic [31:0] addr, logic [31:0] data,
                          logic [1:0] size, bit uns, logic [4:0] rd, bit flag,
                          int unsigned rdly, int unsigned sdly, logic [31:0] rdata);
        bit          mis;
        bit          exp_flag;
        logic [31:0] exp_data;
        mis      = ref_mis(addr, size);
        exp_flag = flag && !st && rd != 0;
        exp_data = ref_load(rdata, addr, size, uns);
        @(negedge clk);
        ex_valid_i = 1'b1; ex_mem_ren_i = !st; ex_mem_wen_i = st;
        ex_result_i = addr; ex_store_data_i = data; ex_mem_size_i = size;
        ex_mem_unsigned_i = uns; ex_wb_addr_i = rd; ex_wb_flag_i = flag;
        @(negedge clk);
        if (mis) begin
            ex_valid_i = 1'b0;
            if (lsu_misalign_o !== 1'b1 || mem_req_valid_o !== 1'b0 || wb_flag_o !== 1'b0 || ex_ready_o !== 1'b1) begin
                errors++; $display("FAIL %s misalign: got mis %b req %b wb %b ready %b want 1/0/0/1", name, lsu_misalign_o, mem_req_valid_o, wb_flag_o, ex_ready_o);
            end
            checks++;
            @(negedge clk);
            if (lsu_misalign_o !== 1'b0 || mem_req_valid_o !== 1'b0 || ex_ready_o !== 1'b1) begin
                errors++; $display("FAIL %s misalign_pulse: got mis %b req %b ready %b want 0/0/1", name, lsu_misalign_o, mem_req_valid_o, ex_ready_o);
            end
            checks++;
            return;
        end
        for (int unsigned c = 0; c <= rdly; c++) begin
            if (c > 0) @(negedge clk);
            garbage_upstream();
            if (mem_req_valid_o !== 1'b1 || ex_ready_o !== 1'b0 || wb_flag_o !== 1'b0) begin
                errors++; $display("FAIL %s req_ctrl[%0d]: got req %b ready %b wb %b want 1/0/0", name, c, mem_req_valid_o, ex_ready_o, wb_flag_o);
            end
            checks++;
            if (mem_req_addr_o !== (addr & ~32'h3) || mem_req_wen_o !== st || mem_req_wstrb_o !== ref_strb(st, addr, size)) begin
                errors++; $display("FAIL %s req_fields[%0d]: got %h/%b/%b want %h/%b/%b", name, c, mem_req_addr_o, mem_req_wen_o, mem_req_wstrb_o, addr & ~32'h3, st, ref_strb(st, addr, size));
            end
            checks++;
            if (st && mem_req_wdata_o !== ref_wdata(data, size)) begin
                errors++; $display("FAIL %s req_wdata[%0d]: got %h want %h", name, c, mem_req_wdata_o, ref_wdata(data, size));
            end
            checks++;
            mem_req_ready_i = (c == rdly);
            mem_rsp_valid_i = (c < rdly) ? 1'($urandom % 2) : 1'b0;
            mem_rsp_rdata_i = $urandom;
        end
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        for (int unsigned c = 0; c <= sdly; c++) begin
            if (c > 0) @(negedge clk);
            garbage_upstream();
            if (mem_req_valid_o !== 1'b0 || ex_ready_o !== 1'b0 || wb_flag_o !== 1'b0) begin
                errors++; $display("FAIL %s wait_ctrl[%0d]: got req %b ready %b wb %b want 0/0/0", name, c, mem_req_valid_o, ex_ready_o, wb_flag_o);
            end
            checks++;
        end
        mem_rsp_valid_i = 1'b1;
        mem_rsp_rdata_i = rdata;
        @(negedge clk);
        mem_rsp_valid_i = 1'b0;
        ex_valid_i = 1'b0;
        if (wb_flag_o !== exp_flag || ex_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
            errors++; $display("FAIL %s commit_ctrl: got wb %b ready %b req %b want %b/1/0", name, wb_flag_o, ex_ready_o, mem_req_valid_o, exp_flag);
        end
        checks++;
        if (exp_flag && (wb_addr_o !== rd || wb_data_o !== exp_data)) begin
            errors++; $display("FAIL %s commit_data: got %0d/%h want %0d/%h", name, wb_addr_o, wb_data_o, rd, exp_data);
        end
        checks++;
        @(negedge clk);
        if (wb_flag_o !== 1'b0) begin errors++; $display("FAIL %s commit_pulse: got %b want 0", name, wb_flag_o); end
        checks++;
    endtask

    task automatic test_directed_mem();
        do_mem("lb",      0, 32'h1003, 32'h0,         2'd0, 0, 5'd10, 1, 3, 1, 32'h80FF_FFFF);
        do_mem("lbu",     0, 32'h1003, 32'h0,         2'd0, 1, 5'd11, 1, 3, 0, 32'h80FF_FFFF);
        do_mem("sh",      1, 32'h2002, 32'hAAAA_BEEF, 2'd1, 0, 5'd12, 1, 1, 2, 32'h5555_5555);
        do_mem("lw_mis",  0, 32'h3001, 32'h0,         2'd2, 0, 5'd13, 1, 0, 0, 32'h0);
        do_mem("lw_rd0",  0, 32'h3000, 32'h0,         2'd2, 0, 5'd0,  1, 0, 1, 32'hDEAD_BEEF);
        do_mem("lh_neg",  0, 32'h3006, 32'h0,         2'd1, 0, 5'd14, 1, 2, 0, 32'h9234_5678);
        do_mem("sb",      1, 32'h4001, 32'h0000_00A5, 2'd0, 0, 5'd15, 1, 0, 0, 32'h0);
        do_mem("size3",   0, 32'h4000, 32'h0,         2'd3, 0, 5'd16, 1, 0, 0, 32'h0);
    endtask

    task automatic test_random_mem(int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            do_mem("rand", 1'($urandom % 2), $urandom, $urandom, 2'($urandom % 4), 1'($urandom % 2),
                   5'($urandom % 32), 1'($urandom % 2), $urandom % 4, $urandom % 3, $urandom);
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        ex_valid_i = 1'b1; ex_mem_ren_i = 1'b1; ex_mem_wen_i = 1'b0;
        ex_result_i = 32'h5000; ex_mem_size_i = 2'd2; ex_wb_addr_i = 5'd7; ex_wb_flag_i = 1'b1;
        @(negedge clk);
        ex_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        if (mem_req_valid_o !== 1'b0 || ex_ready_o !== 1'b0) begin
            errors++; $display("FAIL rstwait_in_wait: got req %b ready %b want 0/0", mem_req_valid_o, ex_ready_o);
        end
        checks++;
        rst = 1'b1;
        #1;
        if (mem_req_valid_o !== 1'b0 || wb_flag_o !== 1'b0 || ex_ready_o !== 1'b1 || wb_addr_o !== 5'd0 || wb_data_o !== 32'd0 || lsu_misalign_o !== 1'b0) begin
            errors++; $display("FAIL rstwait_async: got req %b wb %b ready %b addr %0d data %h mis %b want 0/0/1/0/0/0", mem_req_valid_o, wb_flag_o, ex_ready_o, wb_addr_o, wb_data_o, lsu_misalign_o);
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_rdata_i = 32'hCAFE_F00D;
        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_rsp_valid_i = 1'b0;
            if (wb_flag_o !== 1'b0 || wb_data_o !== 32'd0 || wb_addr_o !== 5'd0 || ex_ready_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
                errors++; $display("FAIL rstwait_stray[%0d]: got wb %b data %h addr %0d ready %b req %b want 0/0/0/1/0", c, wb_flag_o, wb_data_o, wb_addr_o, ex_ready_o, mem_req_valid_o);
            end
            checks++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_back_to_back(20);
        test_directed_mem();
        test_reset_in_wait();
        test_random_mem(60);
        test_alu_back_to_back(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060072_lsu_stage.md
YSYX_23060072_LSU_STAGE -- requirements
Module: ysyx_23060072_lsu_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous assert, active-high.
REQ-003 ex_valid_i  in  1  upstream (execute) instruction valid.
REQ-004 ex_ready_o  out  1  stage can accept; transfer when ex_valid_i & ex_ready_o at a rising edge.
REQ-005 ex_wb_flag_i  in  1  instruction writes rd.
REQ-006 ex_wb_addr_i  in  5  rd index.
REQ-007 ex_result_i  in  32  ALU result; effective address for memory ops.
REQ-008 ex_store_data_i  in  32  rs2 store data.
REQ-009 ex_mem_ren_i / ex_mem_wen_i  in  1 each  load / store; never both high.
REQ-010 ex_mem_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 ex_mem_unsigned_i  in  1  zero-extend load (LBU/LHU).
REQ-012 mem_req_valid_o / mem_req_ready_i  out/in  1 each  bus request handshake.
REQ-013 mem_req_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-014 mem_req_wen_o, mem_req_wdata_o, mem_req_wstrb_o  out  1/32/4  write enable, lane-replicated data, byte strobes.
REQ-015 mem_rsp_valid_i, mem_rsp_rdata_i  in  1/32  response pulse and read word (one response per request, loads and stores).
REQ-016 wb_flag_o, wb_addr_o, wb_data_o  out  1/5/32  registered writeback to wb_stage.
REQ-017 lsu_misalign_o  out  1  one-cycle pulse on misaligned/illegal access.

Function
REQ-018 The block SHALL implement FSM IDLE, REQ, WAIT; ex_ready_o SHALL equal (state==IDLE).
REQ-019 Non-memory op accepted at edge N SHALL drive wb_flag_o=ex_wb_flag_i&(ex_wb_addr_i!=0), wb_addr_o, wb_data_o=ex_result_i in the cycle after N; state stays IDLE (back-to-back, 1 op/cycle).
REQ-020 Aligned memory op accepted at edge N SHALL enter REQ; mem_req_valid_o high from cycle after N and held with stable addr/wen/wdata/wstrb until mem_req_ready_i sampled high, then WAIT.
REQ-021 In WAIT, mem_rsp_valid_i at edge K SHALL commit: wb outputs update in cycle after K, state returns to IDLE; mem_rsp_valid_i outside WAIT SHALL be ignored.
REQ-022 wb_flag_o SHALL be high exactly one cycle per committing instruction and low otherwise; stores SHALL commit with wb_flag_o=0; rd=x0 SHALL force wb_flag_o=0.
REQ-023 Store byte: wstrb=4'b0001<<addr[1:0], wdata={4{data[7:0]}}; half: wstrb=addr[1]?1100:0011, wdata={2{data[15:0]}}; word: 1111, data; loads: wen=0, wstrb=0000.
REQ-024 Load: lane = rdata>>(8*addr[1:0]); byte/half sign-extended from bit 7/15 unless ex_mem_unsigned_i, word unchanged.
REQ-025 Misaligned (half addr[0]=1, word addr[1:0]!=0) or size 11: no bus request, lsu_misalign_o and wb_flag_o=0 for the cycle after acceptance, state stays IDLE.
REQ-026 Address, size, unsigned, rd and wb_flag SHALL be latched at acceptance; upstream inputs SHALL be ignored while not IDLE.

Reset
REQ-027 rst high SHALL immediately force state=IDLE, mem_req_valid_o=0, wb_flag_o=0, lsu_misalign_o=0, wb_addr_o=0, wb_data_o=0, ex_ready_o=1 on release.
REQ-028 Reset during REQ/WAIT SHALL abandon the access; a later stray mem_rsp_valid_i SHALL produce no commit.

Verification
REQ-029 ALU op rd=5 result 0x1234 at edge N -> wb_flag_o=1, wb_addr_o=5, wb_data_o=0x1234 in cycle after N only; next op accepted same cycle.
REQ-030 LB addr 0x1003, ready delayed 3 cycles, rdata 0x80FF_FFFF -> req addr 0x1000 held 4 cycles, wb_data_o=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-031 SH addr 0x2002 data 0xAAAA_BEEF -> wstrb 1100, wdata 0xBEEF_BEEF, wen=1; commit with wb_flag_o=0.
REQ-032 LW addr 0x3001 -> no mem_req_valid_o, lsu_misalign_o one-cycle pulse, ex_ready_o stays 1.
REQ-033 rst asserted in WAIT, rsp arrives 2 cycles after release -> outputs zero, no wb_flag_o pulse, ex_ready_o=1.
REQ-034 LW rd=0 rdata 0xDEAD_BEEF -> wb_flag_o stays 0.
